multicycle_control: RTL

- Multicycle successor to the single-cycle control decoder.
- Moore FSM that sequences fetch, decode, execute, memory and writeback over several clocks, with memory-ready handshaking.
- ALU-control decode width is configurable, with an optional extended-branch mode.
- Sits between the instruction register / ALU flags and the shared-memory multicycle datapath.

---
 rtl/multicycle_control_if.sv | 34 +++
 rtl/multicycle_control.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_if.sv
// Control bundle between the multicycle controller (master) and the
// instruction register / ALU flags / shared-memory datapath (slave).
interface multicycle_control_if #(
    parameter int ALUCTRL_W = 4
);
    logic [31:0]          instr;
    logic                 zero;
    logic                 lt;
    logic                 ltu;
    logic                 mem_ready;
    logic                 PCWrite;
    logic                 AdrSrc;
    logic                 MemWrite;
    logic                 IRWrite;
    logic [1:0]           ResultSrc;
    logic [1:0]           ALUSrcA;
    logic [1:0]           ALUSrcB;
    logic [1:0]           ImmSrc;
    logic [ALUCTRL_W-1:0] ALUctrl;
    logic                 RegWrite;
    logic                 illegal;

    modport master (
        input  instr, zero, lt, ltu, mem_ready,
        output PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA,
               ALUSrcB, ImmSrc, ALUctrl, RegWrite, illegal
    );

    modport slave (
        output instr, zero, lt, ltu, mem_ready,
        input  PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA,
               ALUSrcB, ImmSrc, ALUctrl, RegWrite, illegal
    );
endinterface

// File: rtl/multicycle_control.sv
// Moore FSM sequencing fetch/decode/execute/memory/writeback with memory-ready
// handshaking. Macro BRANCH_EXT_EN adds bne/blt/bge/bltu/bgeu.
module multicycle_control #(
    parameter int ALUCTRL_W    = 4,
    parameter bit ILLEGAL_TRAP = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    multicycle_control_if.master bus,
    output logic [3:0]           state_o
);
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_JAL      = 4'd9,
        S_BRANCH   = 4'd10,
        S_TRAP     = 4'd11
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2,
                           ALU_OR  = 4'd3, ALU_XOR = 4'd4, ALU_SLT = 4'd5,
                           ALU_SLL = 4'd6, ALU_SRL = 4'd7, ALU_SRA = 4'd8,
                           ALU_SLTU = 4'd9;

    localparam bit     NARROW_ALU = (ALUCTRL_W == 32'sd3);
    localparam state_t S_ILL      = ILLEGAL_TRAP ? S_TRAP : S_FETCH;

    function automatic logic [3:0] alu_decode(input logic [2:0] f3,
                                              input logic       f7b5,
                                              input logic       rtype);
        case (f3)
            3'b000:  alu_decode = (rtype && f7b5) ? ALU_SUB : ALU_ADD;
            3'b001:  alu_decode = ALU_SLL;
            3'b010:  alu_decode = ALU_SLT;
            3'b011:  alu_decode = ALU_SLTU;
            3'b100:  alu_decode = ALU_XOR;
            3'b101:  alu_decode = f7b5 ? ALU_SRA : ALU_SRL;
            3'b110:  alu_decode = ALU_OR;
            3'b111:  alu_decode = ALU_AND;
            default: alu_decode = ALU_ADD;
        endcase
    endfunction

    state_t     state_q, state_d;
    logic [6:0] opcode_s;
    logic [2:0] funct3_s;
    logic [3:0] exec_op_s, alu_op_s;
    logic       unencodable_s, branch_ok_s, taken_s;
    logic       pc_write_s, adr_src_s, mem_write_s, ir_write_s;
    logic       reg_write_s, illegal_s;
    logic [1:0] result_src_s, alu_src_a_s, alu_src_b_s, imm_src_s;
    logic       unused_s;

    assign opcode_s      = bus.instr[6:0];
    assign funct3_s      = bus.instr[14:12];
    assign exec_op_s     = alu_decode(funct3_s, bus.instr[30], opcode_s == OP_R);
    // SRA and SLTU have no code below 8, so a 3-bit ALU cannot express them.
    assign unencodable_s = NARROW_ALU && exec_op_s[3];
    assign unused_s      = ^{bus.instr[31], bus.instr[29:15], bus.instr[11:7],
                             bus.lt, bus.ltu};

    // State register; reset aborts any access in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Branch legality and outcome from funct3 and the ALU flags.
    always_comb begin
`ifdef BRANCH_EXT_EN
        branch_ok_s = (funct3_s != 3'b010) && (funct3_s != 3'b011);
        case (funct3_s)
            3'b000:  taken_s = bus.zero;
            3'b001:  taken_s = !bus.zero;
            3'b100:  taken_s = bus.lt;
            3'b101:  taken_s = !bus.lt;
            3'b110:  taken_s = bus.ltu;
            3'b111:  taken_s = !bus.ltu;
            default: taken_s = 1'b0;
        endcase
`else
        branch_ok_s = (funct3_s == 3'b000);
        taken_s     = bus.zero;
`endif
    end

    // Immediate format follows the opcode in every state.
    always_comb begin
        case (opcode_s)
            OP_STORE:  imm_src_s = 2'b01;
            OP_BRANCH: imm_src_s = 2'b10;
            OP_JAL:    imm_src_s = 2'b11;
            default:   imm_src_s = 2'b00;
        endcase
    end

    // Next-state and Moore control decode.
    always_comb begin
        state_d      = state_q;
        pc_write_s   = 1'b0;
        adr_src_s    = 1'b0;
        mem_write_s  = 1'b0;
        ir_write_s   = 1'b0;
        reg_write_s  = 1'b0;
        illegal_s    = 1'b0;
        result_src_s = 2'b00;
        alu_src_a_s  = 2'b00;
        alu_src_b_s  = 2'b00;
        alu_op_s     = ALU_ADD;
        case (state_q)
            S_FETCH: begin
                alu_src_b_s  = 2'b10;
                result_src_s = 2'b10;
                ir_write_s   = bus.mem_ready;
                pc_write_s   = bus.mem_ready;
                state_d      = bus.mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                alu_src_a_s = 2'b01;
                alu_src_b_s = 2'b01;
                case (opcode_s)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_R:      state_d = unencodable_s ? S_ILL : S_EXECR;
                    OP_I:      state_d = unencodable_s ? S_ILL : S_EXECI;
                    OP_BRANCH: state_d = branch_ok_s ? S_BRANCH : S_ILL;
                    OP_JAL:    state_d = S_JAL;
                    default:   state_d = S_ILL;
                endcase
            end
            S_MEMADR: begin
                alu_src_a_s = 2'b10;
                alu_src_b_s = 2'b01;
                state_d     = (opcode_s == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                adr_src_s = 1'b1;
                state_d   = bus.mem_ready ? S_MEMWB : S_MEMREAD;
            end
            S_MEMWB: begin
                result_src_s = 2'b01;
                reg_write_s  = 1'b1;
                state_d      = S_FETCH;
            end
            S_MEMWRITE: begin
                adr_src_s   = 1'b1;
                mem_write_s = 1'b1;
                state_d     = bus.mem_ready ? S_FETCH : S_MEMWRITE;
            end
            S_EXECR, S_EXECI: begin
                alu_src_a_s = 2'b10;
                alu_src_b_s = (state_q == S_EXECI) ? 2'b01 : 2'b00;
                alu_op_s    = exec_op_s;
                state_d     = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write_s = 1'b1;
                state_d     = S_FETCH;
            end
            S_JAL: begin
                alu_src_a_s = 2'b01;
                alu_src_b_s = 2'b10;
                pc_write_s  = 1'b1;
                state_d     = S_ALUWB;
            end
            S_BRANCH: begin
                alu_src_a_s = 2'b10;
                alu_op_s    = ALU_SUB;
                pc_write_s  = taken_s;
                state_d     = S_FETCH;
            end
            S_TRAP: begin
                illegal_s = 1'b1;
                state_d   = S_TRAP;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    assign bus.PCWrite   = pc_write_s;
    assign bus.AdrSrc    = adr_src_s;
    assign bus.MemWrite  = mem_write_s;
    assign bus.IRWrite   = ir_write_s;
    assign bus.ResultSrc = result_src_s;
    assign bus.ALUSrcA   = alu_src_a_s;
    assign bus.ALUSrcB   = alu_src_b_s;
    assign bus.ImmSrc    = imm_src_s;
    assign bus.ALUctrl   = alu_op_s[ALUCTRL_W-1:0];
    assign bus.RegWrite  = reg_write_s;
    assign bus.illegal   = illegal_s;
    assign state_o       = state_q;
endmodule
